// File: rtl/morse_pkg.sv
// Shared symbol codes, element-FSM states and Morse timing ratios for the
// Morse receive path.
package morse_pkg;

    localparam logic [1:0] SYM_DOT    = 2'd0;
    localparam logic [1:0] SYM_DASH   = 2'd1;
    localparam logic [1:0] SYM_LETTER = 2'd2;
    localparam logic [1:0] SYM_WORD   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } elem_state_e;

    localparam int unsigned DASH_UNITS   = 2;
    localparam int unsigned LETTER_UNITS = 2;
    localparam int unsigned WORD_UNITS   = 5;

endpackage

// File: rtl/morse_receiver_if.sv
// Symbol stream from the Morse receiver to the character decoder
// (valid/ready handshake).
interface morse_receiver_if;
    import morse_pkg::*;

    logic [1:0] sym;
    logic       sym_valid;
    logic       sym_ready;

    modport master (output sym, output sym_valid, input  sym_ready);
    modport slave  (input  sym, input  sym_valid, output sym_ready);

endinterface

// File: rtl/morse_tone_detect.sv
// Tone presence detector: synchronises the raw tone input, checks each
// half-period against the expected tone and recovers the key envelope.
module morse_tone_detect #(
    parameter int unsigned TONE_HALF = 27_273,
    parameter int unsigned CNT_W     = 24
) (
    input  logic clk_24,
    input  logic rst,
    input  logic tone_in,
    output logic tone_on
);

    localparam logic [CNT_W-1:0] INT_LO  = CNT_W'(TONE_HALF * 3 / 4);
    localparam logic [CNT_W-1:0] INT_HI  = CNT_W'(TONE_HALF * 5 / 4);
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(2 * TONE_HALF);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [1:0]       run_q, run_d;
    logic             tone_q, tone_d;
    logic             edge_seen;
    logic             in_range;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_24) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            edge_cnt_q <= '0;
            run_q      <= 2'd0;
            tone_q     <= 1'b0;
        end else begin
            sync1_q    <= tone_in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            edge_cnt_q <= edge_cnt_d;
            run_q      <= run_d;
            tone_q     <= tone_d;
        end
    end

    assign edge_seen = sync2_q ^ prev_q;
    assign in_range  = (edge_cnt_q >= INT_LO) && (edge_cnt_q <= INT_HI);

    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        edge_cnt_d = (edge_cnt_q == CNT_MAX) ? edge_cnt_q : edge_cnt_q + CNT_W'(1);
        run_d      = run_q;
        tone_d     = tone_q;
        if (edge_seen) begin
            // edge_cnt then equals the interval length when the next edge lands
            edge_cnt_d = CNT_W'(1);
            if (in_range) begin
                run_d = (run_q == 2'd2) ? 2'd2 : run_q + 2'd1;
                if (run_d == 2'd2) tone_d = 1'b1;
            end else begin
                run_d = 2'd0;
            end
        end else if (edge_cnt_q >= TIMEOUT) begin
            tone_d = 1'b0;
        end
    end

    assign tone_on = tone_q;

endmodule

// File: rtl/morse_receiver.sv
// Morse receiver top: tone detector, mark/space element FSM and a one-deep
// symbol output register with sticky overflow.
module morse_receiver
    import morse_pkg::*;
#(
    parameter int unsigned TONE_HALF   = 27_273,
    parameter int unsigned UNIT_CYCLES = 1_440_000,
    parameter int unsigned CNT_W       = 24
) (
    input  logic              clk_24,
    input  logic              rst,
    input  logic              tone_in,
    output logic              tone_on,
    output logic              overflow,
    morse_receiver_if.master  sym_if
);

    localparam logic [CNT_W-1:0] DASH_LEN   = CNT_W'(DASH_UNITS * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] LETTER_LEN = CNT_W'(LETTER_UNITS * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_LEN   = CNT_W'(WORD_UNITS * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] DUR_MAX    = '1;

    elem_state_e      state_q, state_d;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic             tone_prev_q;
    logic [1:0]       sym_q, sym_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             rise, fall;
    logic             emit;
    logic [1:0]       emit_sym;

    morse_tone_detect #(
        .TONE_HALF (TONE_HALF),
        .CNT_W     (CNT_W)
    ) u_detect (
        .clk_24  (clk_24),
        .rst     (rst),
        .tone_in (tone_in),
        .tone_on (tone_on)
    );

    always_ff @(posedge clk_24) begin
        if (rst) begin
            state_q     <= IDLE;
            dur_q       <= '0;
            tone_prev_q <= 1'b0;
            sym_q       <= SYM_DOT;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dur_q       <= dur_d;
            tone_prev_q <= tone_on;
            sym_q       <= sym_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign rise = tone_on & ~tone_prev_q;
    assign fall = ~tone_on & tone_prev_q;

    // dur restarts at 1 so it includes the cycle in which the edge of tone_on
    // was observed; a mark of N tone_on cycles then reads dur == N at its fall.
    always_comb begin
        state_d  = state_q;
        dur_d    = (dur_q == DUR_MAX) ? dur_q : dur_q + CNT_W'(1);
        emit     = 1'b0;
        emit_sym = SYM_DOT;
        case (state_q)
            IDLE: begin
                dur_d = '0;
                if (rise) begin
                    state_d = MARK;
                    dur_d   = CNT_W'(1);
                end
            end
            MARK: begin
                if (fall) begin
                    emit     = 1'b1;
                    emit_sym = (dur_q >= DASH_LEN) ? SYM_DASH : SYM_DOT;
                    state_d  = SPACE;
                    dur_d    = CNT_W'(1);
                end
            end
            SPACE: begin
                if (rise) begin
                    state_d = MARK;
                    dur_d   = CNT_W'(1);
                end else if (dur_q == LETTER_LEN) begin
                    emit     = 1'b1;
                    emit_sym = SYM_LETTER;
                end else if (dur_q == WORD_LEN) begin
                    emit     = 1'b1;
                    emit_sym = SYM_WORD;
                    state_d  = IDLE;
                    dur_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                dur_d   = '0;
            end
        endcase
    end

    always_comb begin
        sym_d   = sym_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (emit) begin
            // the held symbol wins; a new one only loads into a free or draining slot
            if (!valid_q || sym_if.sym_ready) begin
                sym_d   = emit_sym;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && sym_if.sym_ready) begin
            valid_d = 1'b0;
        end
    end

    assign sym_if.sym       = sym_q;
    assign sym_if.sym_valid = valid_q;
    assign overflow         = ovf_q;

endmodule

// File: tb/tb_morse_receiver.sv
// Self-checking bench for morse_receiver: directed tone/key patterns, with a
// scoreboard queue of expected symbols checked by an independent monitor.
module tb_morse_receiver;
    import morse_pkg::*;

    logic clk_24;
    logic rst;
    logic tone_in;
    logic tone_on;
    logic overflow;

    morse_receiver_if sym_if ();

    morse_receiver #(
        .TONE_HALF   (10),
        .UNIT_CYCLES (400),
        .CNT_W       (24)
    ) dut (
        .clk_24   (clk_24),
        .rst      (rst),
        .tone_in  (tone_in),
        .tone_on  (tone_on),
        .overflow (overflow),
        .sym_if   (sym_if)
    );

    int tests_run = 0;
    int tests_failed = 0;
    logic [1:0] exp_q[$];

    initial clk_24 = 1'b0;
    always #5 clk_24 = ~clk_24;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk_24);
    endtask

    task automatic toggle();
        tone_in = ~tone_in;
    endtask

    // Keys a tone burst that holds tone_on high for exactly len cycles;
    // returns on the cycle of its last toggle.
    task automatic mark(input int len);
        int t = 0;
        toggle();
        while (t + 10 < len) begin
            repeat (10) tick();
            t += 10;
            toggle();
        end
        repeat (len - t) tick();
        toggle();
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor samples just after the driver's negedge updates, away from posedge.
    initial begin
        forever begin
            @(negedge clk_24);
            #1;
            if (!rst && sym_if.sym_valid && sym_if.sym_ready) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_sym: got %0d, expected none at %0t",
                             sym_if.sym, $time);
                end else begin
                    check("sym", sym_if.sym, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic rose;
        rst = 1'b1;
        tone_in = 1'b0;
        sym_if.sym_ready = 1'b1;

        // Reset with a toggling input
        repeat (5) begin
            tick();
            toggle();
        end
        tick();
        check("rst_tone_on", tone_on, 0);
        check("rst_sym_valid", sym_if.sym_valid, 0);
        check("rst_sym", sym_if.sym, SYM_DOT);
        check("rst_overflow", overflow, 0);
        tone_in = 1'b0;
        rst = 1'b0;
        repeat (30) tick();
        check("quiet_tone_on", tone_on, 0);

        // Tone detect: second valid interval raises tone_on
        toggle();
        repeat (10) tick();
        toggle();
        repeat (10) tick();
        toggle();
        exp_q.push_back(SYM_DOT);
        exp_q.push_back(SYM_LETTER);
        exp_q.push_back(SYM_WORD);
        repeat (2) tick();
        check("tone_rise_early", tone_on, 0);
        tick();
        check("tone_rise", tone_on, 1);
        repeat (19) tick();
        check("tone_hold_19", tone_on, 1);
        tick();
        check("tone_fall_20", tone_on, 0);
        repeat (2100) tick();
        wait_drain("drain_burst");

        // Half-period of 5 is out of range
        rose = 1'b0;
        repeat (40) begin
            toggle();
            repeat (5) begin
                tick();
                rose |= tone_on;
            end
        end
        check("fast_no_tone", rose, 0);
        repeat (2100) tick();

        // Letter A
        exp_q.push_back(SYM_DOT);
        exp_q.push_back(SYM_DASH);
        exp_q.push_back(SYM_LETTER);
        exp_q.push_back(SYM_WORD);
        mark(400);
        repeat (400) tick();
        mark(1200);
        repeat (2100) tick();
        wait_drain("drain_a");
        repeat (3000) tick();
        check("idle_quiet", sym_if.sym_valid, 0);

        // Dash boundary: 800 -> DASH, 799 -> DOT
        exp_q.push_back(SYM_DASH);
        exp_q.push_back(SYM_LETTER);
        exp_q.push_back(SYM_WORD);
        mark(800);
        repeat (2100) tick();
        wait_drain("drain_800");
        exp_q.push_back(SYM_DOT);
        exp_q.push_back(SYM_LETTER);
        exp_q.push_back(SYM_WORD);
        mark(799);
        repeat (2100) tick();
        wait_drain("drain_799");

        // Space of 799 cycles emits no LETTER
        exp_q.push_back(SYM_DOT);
        exp_q.push_back(SYM_DOT);
        exp_q.push_back(SYM_LETTER);
        exp_q.push_back(SYM_WORD);
        mark(400);
        repeat (799) tick();
        mark(400);
        repeat (2100) tick();
        wait_drain("drain_space799");
        check("pre_bp_overflow", overflow, 0);

        // Backpressure through A
        sym_if.sym_ready = 1'b0;
        exp_q.push_back(SYM_DOT);
        mark(400);
        repeat (400) tick();
        mark(1200);
        repeat (2100) tick();
        check("bp_valid", sym_if.sym_valid, 1);
        check("bp_sym_held", sym_if.sym, SYM_DOT);
        check("bp_overflow", overflow, 1);
        sym_if.sym_ready = 1'b1;
        tick();
        tick();
        check("bp_valid_clear", sym_if.sym_valid, 0);
        check("bp_queue", exp_q.size(), 0);
        exp_q.push_back(SYM_DOT);
        exp_q.push_back(SYM_LETTER);
        exp_q.push_back(SYM_WORD);
        mark(400);
        repeat (2100) tick();
        wait_drain("drain_after_bp");
        check("overflow_sticky", overflow, 1);

        // Reset 600 cycles into a mark
        toggle();
        repeat (60) begin
            repeat (10) tick();
            toggle();
        end
        rst = 1'b1;
        repeat (5) tick();
        tone_in = 1'b0;
        rst = 1'b0;
        check("midrst_fsm", dut.state_q, IDLE);
        check("midrst_valid", sym_if.sym_valid, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_tone_on", tone_on, 0);
        repeat (2100) tick();
        check("midrst_quiet", sym_if.sym_valid, 0);

        // Letter E after the reset
        exp_q.push_back(SYM_DOT);
        exp_q.push_back(SYM_LETTER);
        exp_q.push_back(SYM_WORD);
        mark(400);
        repeat (2100) tick();
        wait_drain("drain_e");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
